// File: rtl/rate_sel_ctrl_pkg.sv
// Shared encodings and defaults for the tick-rate mux select/enable controller.
package rate_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_ON  = 2'd1,
    ST_GAP = 2'd2
  } state_t;

  localparam logic [1:0] SEL_0P5  = 2'd0;
  localparam logic [1:0] SEL_1    = 2'd1;
  localparam logic [1:0] SEL_2    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam int NUM_SEL_DEF = 3;
  localparam int GAP_DEF     = 4;
  localparam int DWELL_DEF   = 8;

endpackage

// File: rtl/rate_sel_ctrl_rise_edge.sv
// Rising-edge detector with configurable history reset value.
// Optional macro RATE_SEL_SYNC_EN inserts a 2-flop synchronizer ahead of the detector.
module rise_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_s;
  logic prev;

`ifdef RATE_SEL_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign d_s = sync_p1;
`else
  assign d_s = d;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev <= RST_VAL;
    else     prev <= d_s;
  end

  assign rise = d_s & ~prev;

endmodule

// File: rtl/rate_sel_ctrl.sv
// Select/enable controller for the 0.5/1/2 Hz tick mux; E is dropped for a guard gap around
// every select change. Optional macro RATE_SEL_SYNC_EN adds input synchronizers (in rise_edge).
module rate_sel_ctrl
  import rate_sel_ctrl_pkg::*;
#(
  parameter int NUM_SEL = NUM_SEL_DEF,
  parameter int DWELL   = DWELL_DEF,
  parameter int GAP     = GAP_DEF
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       next_req,
  input  logic       en_toggle,
  input  logic       auto_mode,
  input  logic       tick_in,
  output logic [1:0] S,
  output logic       E,
  output logic       busy
);

  localparam int GW = $clog2(GAP);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
  localparam logic [7:0]    DWELL_LAST = 8'(DWELL - 1);
  localparam logic [1:0]    SEL_LAST   = 2'(NUM_SEL - 1);

  function automatic logic [1:0] sel_next(input logic [1:0] s);
    return (s == SEL_LAST) ? SEL_0P5 : s + 2'd1;
  endfunction

  logic next_rise;
  logic tog_rise;
  logic tick_rise;

  rise_edge #(.RST_VAL(1'b1)) u_next (.clk(clki), .rst(rst), .d(next_req),  .rise(next_rise));
  rise_edge #(.RST_VAL(1'b1)) u_tog  (.clk(clki), .rst(rst), .d(en_toggle), .rise(tog_rise));
  rise_edge #(.RST_VAL(1'b1)) u_tick (.clk(clki), .rst(rst), .d(tick_in),   .rise(tick_rise));

  state_t        state;
  logic [7:0]    dwell_cnt;
  logic [GW-1:0] gap_cnt;
  logic          advance;

  // Manual and auto requests in one cycle collapse into a single advance.
  assign advance = next_rise | (auto_mode & tick_rise & (dwell_cnt == DWELL_LAST));

  always_ff @(posedge clki) begin
    if (rst) begin
      state     <= ST_OFF;
      S         <= SEL_0P5;
      E         <= 1'b0;
      busy      <= 1'b0;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          if (tog_rise) begin
            state     <= ST_ON;
            E         <= 1'b1;
            dwell_cnt <= '0;
          end
        end
        ST_ON: begin
          if (tog_rise) begin
            state     <= ST_OFF;
            E         <= 1'b0;
            dwell_cnt <= '0;
          end else if (advance) begin
            state     <= ST_GAP;
            E         <= 1'b0;
            busy      <= 1'b1;
            gap_cnt   <= GAP_LAST;
            dwell_cnt <= '0;
          end else if (auto_mode && tick_rise) begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          // S moves one cycle after E falls, so the mux never sees it change while enabled.
          if (tog_rise) begin
            state <= ST_OFF;
            E     <= 1'b0;
            busy  <= 1'b0;
          end else begin
            if (gap_cnt == GAP_LAST) S <= sel_next(S);
            if (gap_cnt == '0) begin
              state     <= ST_ON;
              E         <= 1'b1;
              busy      <= 1'b0;
              dwell_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt - GW'(1);
            end
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_rate_sel_ctrl.sv
// Randomized and directed bench for rate_sel_ctrl against a behavioural reference model.
module tb_rate_sel_ctrl;

  localparam int NUM_SEL = 3;
  localparam int DWELL   = 8;
  localparam int GAP     = 4;

  logic       clki = 1'b0;
  logic       rst = 1'b1;
  logic       next_req = 1'b0;
  logic       en_toggle = 1'b0;
  logic       auto_mode = 1'b0;
  logic       tick_in = 1'b0;
  logic [1:0] S;
  logic       E;
  logic       busy;

  rate_sel_ctrl #(.NUM_SEL(NUM_SEL), .DWELL(DWELL), .GAP(GAP)) dut (
    .clki(clki), .rst(rst), .next_req(next_req), .en_toggle(en_toggle),
    .auto_mode(auto_mode), .tick_in(tick_in), .S(S), .E(E), .busy(busy)
  );

  always #5 clki = ~clki;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: output on/off flag, age within the guard gap (0 = not in gap),
  // current selection and rises seen in the current dwell.
  bit m_on;
  int m_gap_age;
  int m_sel;
  int m_dwell;
  bit p_nr, p_tg, p_tk;

  function automatic void model_step(bit r, bit nr, bit tg, bit am, bit tk);
    bit nr_r, tg_r, tk_r;
    nr_r = nr && !p_nr;
    tg_r = tg && !p_tg;
    tk_r = tk && !p_tk;
    if (r) begin
      m_on = 0; m_gap_age = 0; m_sel = 0; m_dwell = 0;
      p_nr = 1; p_tg = 1; p_tk = 1;
      return;
    end
    p_nr = nr; p_tg = tg; p_tk = tk;
    if (m_gap_age > 0) begin
      if (tg_r) begin
        m_on = 0; m_gap_age = 0;
      end else begin
        if (m_gap_age == 1) m_sel = (m_sel + 1) % NUM_SEL;
        if (m_gap_age == GAP) begin
          m_gap_age = 0; m_dwell = 0;
        end else m_gap_age++;
      end
    end else if (m_on) begin
      if (tg_r) begin
        m_on = 0; m_dwell = 0;
      end else if (nr_r || (am && tk_r && m_dwell == DWELL - 1)) begin
        m_gap_age = 1; m_dwell = 0;
      end else if (am && tk_r) m_dwell++;
    end else if (tg_r) begin
      m_on = 1; m_dwell = 0;
    end
  endfunction

  task automatic cycle(input bit r, input bit nr, input bit tg, input bit am, input bit tk);
    rst = r; next_req = nr; en_toggle = tg; auto_mode = am; tick_in = tk;
    @(posedge clki);
    model_step(r, nr, tg, am, tk);
    @(negedge clki);
    chk("S_model", int'(S), m_sel);
    chk("E_model", int'(E), int'(m_on && m_gap_age == 0));
    chk("busy_model", int'(busy), int'(m_gap_age > 0));
  endtask

  task automatic chk_out(input string tag, input int s_exp, input int e_exp, input int b_exp);
    chk({tag, "_S"}, int'(S), s_exp);
    chk({tag, "_E"}, int'(E), e_exp);
    chk({tag, "_busy"}, int'(busy), b_exp);
  endtask

  initial begin
    int busy_cycles;
    bit nr, tg, am, tk, r;
    @(negedge clki);

    // Reset with next_req held high through release: no advance, stays OFF.
    cycle(1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    chk_out("reset", 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0, 0);
    chk_out("nr_held", 0, 0, 0);

    // en_toggle rise -> ON right after the edge.
    cycle(0, 1, 1, 0, 0);
    chk_out("turn_on", 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Manual step latency.
    cycle(0, 1, 0, 0, 0);
    chk_out("step_k", 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    chk_out("step_k1", 1, 0, 1);
    busy_cycles = 2;
    cycle(0, 0, 0, 0, 0);
    if (busy) busy_cycles++;
    cycle(0, 0, 0, 0, 0);
    if (busy) busy_cycles++;
    cycle(0, 0, 0, 0, 0);
    chk_out("step_k4", 1, 1, 0);
    chk("busy_len", busy_cycles, GAP);

    // Auto mode: 7 rises do nothing, the 8th starts a gap; three dwells wrap back.
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 0);
    end
    chk_out("auto_7", 1, 1, 0);
    cycle(0, 0, 0, 1, 1);
    chk_out("auto_8", 1, 0, 1);
    repeat (5) cycle(0, 0, 0, 1, 0);
    chk_out("auto_d1", 2, 1, 0);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DWELL; i++) begin
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);
      end
      repeat (4) cycle(0, 0, 0, 1, 0);
    end
    chk_out("auto_wrap", 1, 1, 0);

    // next_req rise during GAP is dropped.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 0);
    chk_out("gap_drop", 2, 1, 0);

    // en_toggle at gap_cnt==2 -> OFF, updated S retained.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk_out("gap_off", 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk_out("reon", 0, 1, 0);

    // Toggle and advance together: toggle wins.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    chk_out("tog_wins", 0, 0, 0);

    // Reset during GAP.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk_out("pre_rst", 1, 0, 1);
    cycle(1, 0, 0, 0, 0);
    chk_out("gap_rst", 0, 0, 0);

    // Randomized traffic.
    nr = 0; tg = 0; am = 0; tk = 0;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0)  nr = ~nr;
      if ($urandom_range(0, 39) == 0) tg = ~tg;
      if ($urandom_range(0, 99) == 0) am = ~am;
      if ($urandom_range(0, 1) == 0)  tk = ~tk;
      cycle(r, nr, tg, am, tk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
